// File: rtl/spi_rom_responder.sv
// spi_rom_responder: answers READ (03h), FAST READ (0Bh) and JEDEC ID (9Fh)
// from an internal byte array. Runs directly on the SPI serial clock.
//
// Handshake: there is no valid/ready pair. A transaction is framed by
// spi_cs (active high). MOSI is sampled on rising clk. MISO is updated on
// falling clk, so the initiator samples it on the following rising edge.
// One rising edge with spi_cs low ends a transaction. The next rising edge
// with spi_cs high may start a new one.
module spi_rom_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              active,
  output logic              bad_cmd,
  output logic [2:0]        fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_ID     = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  typedef logic [DEPTH-1:0][7:0] image_t;

  // Power-up image: the identity pattern byte[a] = a[7:0].
  function automatic image_t init_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) img[i] = i[7:0];
    return img;
  endfunction

  // Memory contents are not touched by reset; only the backdoor writes them.
  image_t mem = init_image();

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [7:0]  cmd_sr, cmd_nxt;
  logic [7:0]  cmd_word;
  logic [23:0] addr_sr, addr_nxt;
  logic        bad_set;
  logic        miso_nxt;
  logic        armed;
  logic [ADDR_W-1:0] rd_idx;

  assign fsm_state = state;
  assign cmd_word  = {cmd_sr[6:0], spi_mosi};
  assign rd_idx    = addr_sr[ADDR_W-1:0];

  // Control state: state, bit counter, command and address shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      cmd_sr  <= 8'd0;
      addr_sr <= 24'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cmd_sr  <= cmd_nxt;
      addr_sr <= addr_nxt;
    end
  end

  // Next-state decode. Chip select low always returns to IDLE and clears the
  // counter while leaving the shift registers untouched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_sr;
    addr_nxt  = addr_sr;
    bad_set   = 1'b0;
    if (!spi_cs) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // After reset a low chip select must be seen before a new start.
          if (armed) begin
            state_nxt = S_CMD;
            cmd_nxt   = cmd_word;
            cnt_nxt   = 6'd1;
          end
        end
        S_CMD: begin
          cmd_nxt = cmd_word;
          if (cnt == 6'd7) begin
            cnt_nxt = 6'd0;
            case (cmd_word)
              8'h03, 8'h0B: state_nxt = S_ADDR;
              8'h9F:        state_nxt = S_ID;
              default: begin
                state_nxt = S_IGNORE;
                bad_set   = 1'b1;
              end
            endcase
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        S_ADDR: begin
          addr_nxt = {addr_sr[22:0], spi_mosi};
          if (cnt == 6'd23) begin
            cnt_nxt   = 6'd0;
            state_nxt = (cmd_sr == 8'h0B) ? S_DUMMY : S_DATA;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        S_DUMMY: begin
          if (cnt == 6'd7) begin
            cnt_nxt   = 6'd0;
            state_nxt = S_DATA;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        S_DATA: begin
          // The 24-bit address wraps naturally from FFFFFFh to 000000h.
          if (cnt == 6'd7) begin
            cnt_nxt  = 6'd0;
            addr_nxt = addr_sr + 24'd1;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        S_ID: begin
          if (cnt == 6'd23) cnt_nxt = 6'd0;
          else              cnt_nxt = cnt + 6'd1;
        end
        S_IGNORE: begin
          state_nxt = S_IGNORE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  // Start qualifier: set by any rising edge with chip select low, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    armed <= 1'b0;
    else if (!spi_cs) armed <= 1'b1;
  end

  // Status outputs: active tracks the next state, bad_cmd is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      bad_cmd <= 1'b0;
    end else begin
      active  <= (state_nxt != S_IDLE);
      bad_cmd <= bad_cmd | bad_set;
    end
  end

  // Output bit selection from the registered state (stable across the low phase).
  always_comb begin
    miso_nxt = 1'b0;
    case (state)
      S_DATA:  miso_nxt = mem[rd_idx][3'd7 - cnt[2:0]];
      S_ID:    miso_nxt = JEDEC_ID[5'd23 - cnt[4:0]];
      default: miso_nxt = 1'b0;
    endcase
  end

  // MISO launches on the falling edge so it is settled for the initiator's rising edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) spi_miso <= 1'b0;
    else          spi_miso <= miso_nxt;
  end

  // Backdoor byte write, only accepted between transactions.
  always_ff @(posedge clk) begin
    if (load_en && !spi_cs) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: drives SPI transactions on the falling edge,
// a monitor collects MISO on rising edges and compares against a queue of
// expected bit groups built from a byte-array reference model.
module tb_spi_rom_responder;

  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [23:0] JEDEC  = 24'hEF4018;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              spi_cs;
  logic              spi_mosi;
  logic              spi_miso;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              active;
  logic              bad_cmd;
  logic [2:0]        fsm_state;

  spi_rom_responder #(
    .ADDR_W   (ADDR_W),
    .JEDEC_ID (JEDEC),
    .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .active   (active),
    .bad_cmd  (bad_cmd),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_n_q[$];
  logic [7:0] ref_mem [DEPTH];
  logic       exp_bad = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] acc = 8'd0;
  int         acc_n = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] v, input int n);
    exp_q.push_back(v);
    exp_n_q.push_back(n);
  endtask

  function automatic logic is_valid_cmd(input logic [7:0] c);
    return (c == 8'h03) || (c == 8'h0B) || (c == 8'h9F);
  endfunction

  // Reference: byte k of the response stream after command/address/dummy.
  function automatic logic [7:0] resp_byte(input logic [7:0] c, input logic [23:0] a, input int k);
    logic [23:0]       id;
    logic [ADDR_W-1:0] idx;
    id = JEDEC;
    if (c == 8'h03 || c == 8'h0B) begin
      idx = ADDR_W'((int'(a) + k) % DEPTH);
      return ref_mem[idx];
    end else if (c == 8'h9F) begin
      case (k % 3)
        0:       return id[23:16];
        1:       return id[15:8];
        default: return id[7:0];
      endcase
    end
    return 8'h00;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (rx_en) begin
      acc   = {acc[6:0], spi_miso};
      acc_n = acc_n + 1;
      if (exp_n_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got bit %0b, expected no data at %0t", spi_miso, $time);
        acc   = 8'd0;
        acc_n = 0;
      end else if (acc_n == exp_n_q[0]) begin
        logic [7:0] e;
        int         n;
        e = exp_q.pop_front();
        n = exp_n_q.pop_front();
        check($sformatf("miso_bits%0d", n), {24'd0, acc}, {24'd0, e});
        acc   = 8'd0;
        acc_n = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, input logic cap);
    spi_cs   = 1'b1;
    spi_mosi = b;
    rx_en    = cap;
    @(negedge clk);
  endtask

  task automatic end_xfer();
    spi_cs   = 1'b0;
    spi_mosi = 1'b0;
    rx_en    = 1'b0;
    load_en  = 1'b0;
    @(negedge clk);
    check("active_after_cs_low", {31'd0, active}, 32'd0);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    spi_cs    = 1'b0;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic xfer(input logic [7:0] c, input logic [23:0] a, input int ndata);
    logic rd;
    int   full, rem;
    rd   = (c == 8'h03) || (c == 8'h0B);
    full = ndata / 8;
    rem  = ndata % 8;
    push_exp(8'h00, 8);
    if (rd) begin
      push_exp(8'h00, 8);
      push_exp(8'h00, 8);
      push_exp(8'h00, 8);
    end
    if (c == 8'h0B) push_exp(8'h00, 8);
    for (int k = 0; k < full; k++) push_exp(resp_byte(c, a, k), 8);
    if (rem != 0) push_exp(resp_byte(c, a, full) >> (8 - rem), rem);
    if (!is_valid_cmd(c)) exp_bad = 1'b1;

    for (int i = 7; i >= 0; i--) drive_bit(c[i], 1'b1);
    check("active_in_xfer", {31'd0, active}, 32'd1);
    check("bad_cmd_after_cmd", {31'd0, bad_cmd}, {31'd0, exp_bad});
    if (rd) for (int i = 23; i >= 0; i--) drive_bit(a[i], 1'b1);
    if (c == 8'h0B) for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < ndata; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    end_xfer();
  endtask

  // Called on a falling edge (or just after) while spi_cs is high.
  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1;
    check("reset_miso", {31'd0, spi_miso}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    check("reset_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    exp_bad = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    int          sel;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = i[7:0];
    reset_n   = 1'b0;
    spi_cs    = 1'b0;
    spi_mosi  = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = 8'd0;
    #12;
    check("por_miso", {31'd0, spi_miso}, 32'd0);
    check("por_active", {31'd0, active}, 32'd0);
    check("por_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // READ from 0, 16 bytes of identity pattern
    xfer(8'h03, 24'h000000, 128);
    // index wrap and aliasing
    xfer(8'h03, 24'h000FFE, 32);
    xfer(8'h03, 24'h001005, 8);
    // FAST READ with dummy byte
    xfer(8'h0B, 24'h000010, 16);
    // JEDEC ID with a backdoor write attempted while selected (must be ignored)
    load_en   = 1'b1;
    load_addr = 12'h020;
    load_data = 8'h5A;
    xfer(8'h9F, 24'h000000, 48);
    xfer(8'h03, 24'h000020, 8);
    // unsupported command: MISO stays 0, bad_cmd sticky
    xfer(8'h05, 24'h000000, 64);
    check("bad_cmd_held", {31'd0, bad_cmd}, 32'd1);

    // abort after 4 data bits, then immediate re-read
    do_load(12'h003, 8'hA5);
    xfer(8'h03, 24'h000003, 4);
    xfer(8'h03, 24'h000003, 8);

    // reset during the address phase
    for (int i = 7; i >= 0; i--) drive_bit(c_read(i), 1'b0);
    for (int i = 0; i < 10; i++) drive_bit(1'b0, 1'b0);
    check("active_before_reset", {31'd0, active}, 32'd1);
    pulse_reset();
    push_exp(8'h00, 8);
    push_exp(8'h00, 8);
    for (int i = 0; i < 16; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    check("idle_until_cs_low", {31'd0, active}, 32'd0);
    end_xfer();
    xfer(8'h03, 24'h000003, 16);

    // reset while MISO is high in the ID stream
    for (int i = 7; i >= 0; i--) drive_bit(c_id(i), 1'b0);
    drive_bit(1'b0, 1'b0);
    #1;
    check("id_bit22_high", {31'd0, spi_miso}, 32'd1);
    pulse_reset();
    end_xfer();
    xfer(8'h9F, 24'h000000, 24);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(ADDR_W'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       c = 8'h03;
        1:       c = 8'h0B;
        2:       c = 8'h9F;
        default: begin
          c = 8'($urandom_range(0, 255));
          while (is_valid_cmd(c)) c = 8'($urandom_range(0, 255));
        end
      endcase
      a = (it == 0) ? 24'hFFFFFD : 24'($urandom_range(0, 24'hFFFFFF));
      xfer(c, a, int'($urandom_range(1, 40)));
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("partial_bits_left", acc_n, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic c_read(input int i);
    logic [7:0] v;
    v = 8'h03;
    return v[i];
  endfunction

  function automatic logic c_id(input int i);
    logic [7:0] v;
    v = 8'h9F;
    return v[i];
  endfunction

endmodule
